// File: rtl/ethernet_sniffer.sv
`default_nettype none
// ============================================================================
// Module   : ethernet_sniffer
// Brief    : Inline Ethernet/IPv4/TCP inspector feeding a packet buffer and
//            counting MAC / IP / port / URL hits per committed packet.
// Revision : 1.0  initial release
// ============================================================================
module ethernet_sniffer #(
    parameter int PIPE_DEPTH = 4,
    parameter int MAX_STR    = 17
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [31:0]          data_in,
    input  logic                 sop,
    input  logic                 eop,
    input  logic [1:0]           empty,
    input  logic [5:0]           error,
    input  logic                 valid,
    input  logic                 ready,
    input  logic                 update_done,
    input  logic [15:0]          flagged_port,
    input  logic [31:0]          flagged_ip,
    input  logic [47:0]          flagged_mac,
    input  logic [MAX_STR*8-1:0] flagged_string,
    input  logic [4:0]           strlen,
    output logic [31:0]          data_out,
    output logic                 write_enable,
    output logic [31:0]          addr_out,
    output logic [63:0]          mac_hits,
    output logic [63:0]          ip_hits,
    output logic [63:0]          port_hits,
    output logic [63:0]          url_hits
);

    localparam int c_HDR_LEN   = 38;
    localparam int c_URL_START = 14;
    localparam int c_SR_LEN    = MAX_STR + 3;

    typedef enum logic [1:0] {IDLE = 2'd0, HEADER = 2'd1, PAYLOAD = 2'd2, DROP = 2'd3} state_t;

    state_t                r_state, w_state_next;
    logic [7:0]            r_offset, w_offset;
    logic [7:0]            r_hdr [c_HDR_LEN];
    logic [7:0]            w_hdr [c_HDR_LEN];
    logic [7:0]            r_sr [c_SR_LEN];
    logic [7:0]            w_sr [c_SR_LEN];
    logic [c_SR_LEN-1:0]   r_sv, w_sv;
    logic [3:0]            r_flags, w_flags, r_pend;    // {url, port, ip, mac}
    logic                  r_err_seen, w_err_seen;
    logic [3:0]            w_url_hit;
    logic [31:0]           r_pipe_d [PIPE_DEPTH-1];
    logic [PIPE_DEPTH-2:0] r_pipe_v;
    logic [31:0]           r_wr_addr;

    logic w_accept, w_err, w_start, w_in_pkt, w_active, w_write, w_eop;
    assign w_accept = valid & ready;
    assign w_err    = |error;
    assign w_start  = w_accept & sop;
    assign w_in_pkt = (r_state == HEADER) || (r_state == PAYLOAD);
    assign w_active = w_start | (w_accept & (r_state != IDLE));
    assign w_write  = w_active & ~w_err & (w_start | w_in_pkt);
    assign w_eop    = w_active & eop;
    assign w_offset = w_start ? 8'd0 : r_offset;
    assign w_err_seen = (~w_start & r_err_seen) | (w_err & (w_start | (r_state != IDLE)));

    always_ff @(posedge clk) begin
        if (n_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_start)
            w_state_next = w_err ? DROP : HEADER;
        else if (w_in_pkt && w_err)
            w_state_next = DROP;
        else if (w_accept && r_state == HEADER && r_offset >= 8'(c_HDR_LEN - 4))
            w_state_next = PAYLOAD;
        if (w_eop)
            w_state_next = IDLE;
    end

    // Header bytes 0..37 are captured by offset so each field can be compared
    // on the word that completes it.
    always_comb begin
        w_hdr = r_hdr;
        for (int k = 0; k < 4; k++) begin
            if (w_offset < 8'(c_HDR_LEN - k))
                w_hdr[w_offset[5:0] + 6'(k)] = data_in[31-8*k -: 8];
        end
    end

    logic [47:0] w_dst_mac, w_src_mac;
    logic [31:0] w_src_ip, w_dst_ip;
    logic [15:0] w_etype, w_src_port, w_dst_port;
    assign w_dst_mac  = {w_hdr[0], w_hdr[1], w_hdr[2], w_hdr[3], w_hdr[4], w_hdr[5]};
    assign w_src_mac  = {w_hdr[6], w_hdr[7], w_hdr[8], w_hdr[9], w_hdr[10], w_hdr[11]};
    assign w_etype    = {w_hdr[12], w_hdr[13]};
    assign w_src_ip   = {w_hdr[26], w_hdr[27], w_hdr[28], w_hdr[29]};
    assign w_dst_ip   = {w_hdr[30], w_hdr[31], w_hdr[32], w_hdr[33]};
    assign w_src_port = {w_hdr[34], w_hdr[35]};
    assign w_dst_port = {w_hdr[36], w_hdr[37]};

    // URL window: newest word lands in the top four bytes; a byte is valid only
    // inside the searched region of the current packet and not trimmed by empty.
    always_comb begin
        w_sr = r_sr;
        w_sv = '0;
        for (int j = 0; j < c_SR_LEN - 4; j++) begin
            w_sr[j] = r_sr[j+4];
            w_sv[j] = r_sv[j+4] & ~w_start;
        end
        for (int k = 0; k < 4; k++) begin
            w_sr[c_SR_LEN-4+k] = data_in[31-8*k -: 8];
            w_sv[c_SR_LEN-4+k] = (w_offset >= 8'(c_URL_START - k)) &&
                                 !(eop && ((3'(k) + {1'b0, empty}) >= 3'd4));
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_align
        logic [MAX_STR-1:0] w_ok;
        for (genvar d = 0; d < MAX_STR; d++) begin : g_byte
            assign w_ok[d] = (5'(d) >= strlen) ||
                             (w_sv[MAX_STR-1+k-d] &&
                              w_sr[MAX_STR-1+k-d] == flagged_string[8*d +: 8]);
        end
        assign w_url_hit[k] = &w_ok;
    end

    always_comb begin
        w_flags = w_start ? 4'b0 : r_flags;
        if (w_active) begin
            if (w_offset == 8'd4  && w_dst_mac == flagged_mac) w_flags[0] = 1'b1;
            if (w_offset == 8'd8  && w_src_mac == flagged_mac) w_flags[0] = 1'b1;
            if (w_offset == 8'd32 && w_etype == 16'h0800 &&
                (w_src_ip == flagged_ip || w_dst_ip == flagged_ip)) w_flags[1] = 1'b1;
            if (w_offset == 8'd36 && w_hdr[23] == 8'h06 &&
                (w_src_port == flagged_port || w_dst_port == flagged_port)) w_flags[2] = 1'b1;
            if (|w_url_hit) w_flags[3] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_offset   <= '0;
            r_sv       <= '0;
            r_flags    <= '0;
            r_err_seen <= 1'b0;
            r_pend     <= '0;
            mac_hits   <= '0;
            ip_hits    <= '0;
            port_hits  <= '0;
            url_hits   <= '0;
            for (int i = 0; i < c_HDR_LEN; i++) r_hdr[i] <= '0;
            for (int i = 0; i < c_SR_LEN; i++)  r_sr[i]  <= '0;
        end else begin
            r_flags    <= w_flags;
            r_err_seen <= w_err_seen;
            if (w_active) begin
                r_offset <= (w_offset < 8'd252) ? w_offset + 8'd4 : w_offset;
                r_hdr    <= w_hdr;
                r_sr     <= w_sr;
                r_sv     <= w_sv;
            end
            // Counters consume the old pending flags before a coincident commit.
            if (w_eop)            r_pend <= w_err_seen ? 4'b0 : w_flags;
            else if (update_done) r_pend <= 4'b0;
            if (update_done) begin
                mac_hits  <= mac_hits  + 64'(r_pend[0]);
                ip_hits   <= ip_hits   + 64'(r_pend[1]);
                port_hits <= port_hits + 64'(r_pend[2]);
                url_hits  <= url_hits  + 64'(r_pend[3]);
            end
        end
    end

    // PIPE_DEPTH-1 internal stages; the output register is the final stage.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            for (int i = 0; i < PIPE_DEPTH - 1; i++) r_pipe_d[i] <= '0;
            r_pipe_v     <= '0;
            data_out     <= '0;
            write_enable <= 1'b0;
            addr_out     <= '0;
            r_wr_addr    <= '0;
        end else begin
            r_pipe_d[0] <= data_in;
            r_pipe_v[0] <= w_write;
            for (int i = 1; i < PIPE_DEPTH - 1; i++) begin
                r_pipe_d[i] <= r_pipe_d[i-1];
                r_pipe_v[i] <= r_pipe_v[i-1];
            end
            write_enable <= r_pipe_v[PIPE_DEPTH-2];
            if (r_pipe_v[PIPE_DEPTH-2]) begin
                data_out  <= r_pipe_d[PIPE_DEPTH-2];
                addr_out  <= r_wr_addr;
                r_wr_addr <= r_wr_addr + 32'd4;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ethernet_sniffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ethernet_sniffer
// Brief    : Directed frames with hand-computed hit counts and a write scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_ethernet_sniffer;

    logic         clk = 1'b0;
    logic         n_rst;
    logic [31:0]  data_in;
    logic         sop, eop, valid, ready, update_done;
    logic [1:0]   empty;
    logic [5:0]   error;
    logic [15:0]  flagged_port;
    logic [31:0]  flagged_ip;
    logic [47:0]  flagged_mac;
    logic [135:0] flagged_string;
    logic [4:0]   strlen;
    logic [31:0]  data_out, addr_out;
    logic         write_enable;
    logic [63:0]  mac_hits, ip_hits, port_hits, url_hits;

    always #5 clk = ~clk;

    ethernet_sniffer #(.PIPE_DEPTH(4), .MAX_STR(17)) u_dut (
        .clk(clk), .n_rst(n_rst), .data_in(data_in), .sop(sop), .eop(eop),
        .empty(empty), .error(error), .valid(valid), .ready(ready),
        .update_done(update_done), .flagged_port(flagged_port),
        .flagged_ip(flagged_ip), .flagged_mac(flagged_mac),
        .flagged_string(flagged_string), .strlen(strlen),
        .data_out(data_out), .write_enable(write_enable), .addr_out(addr_out),
        .mac_hits(mac_hits), .ip_hits(ip_hits), .port_hits(port_hits),
        .url_hits(url_hits)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    logic [31:0] exp_addr = 32'd0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic exp_we;
        if (mon_en) begin
            exp_we = (q.size() > 0) && (q[0].due == cyc);
            check("write_enable", 64'(write_enable), 64'(exp_we));
            if (exp_we) begin
                check("data_out", 64'(data_out), 64'(q[0].data));
                check("addr_out", 64'(addr_out), 64'(exp_addr));
                exp_addr = exp_addr + 32'd4;
                void'(q.pop_front());
            end
        end
    end

    logic [7:0] fb[$];

    task automatic push_bytes(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) fb.push_back(s[i]);
    endtask

    // 54-byte Eth/IPv4/TCP header, then an HTTP request whose Host starts at byte 76+pad.
    task automatic build_frame(input logic [47:0] mac, input logic [31:0] ip,
                               input logic [15:0] port, input int pad,
                               input string host, input bit tail);
        fb.delete();
        push_bytes(64'(mac), 6);
        push_bytes(64'h0200_0000_0001, 6);
        push_bytes(64'h0800, 2);
        push_bytes(64'h4500_003c_0000_4000, 8);
        push_bytes(64'h4006_0000, 4);
        push_bytes(64'h0a00_0001, 4);
        push_bytes(64'(ip), 4);
        push_bytes(64'h1234, 2);
        push_bytes(64'(port), 2);
        push_bytes(64'd0, 8);
        push_bytes(64'h5010_ffff_0000_0000, 8);
        push_str("GET / HTTP/1.1");
        push_bytes(64'h0d0a, 2);
        push_str("Host: ");
        repeat (pad) fb.push_back(8'h78);
        push_str(host);
        if (tail) push_bytes(64'h0d0a_0d0a, 4);
    endtask

    task automatic send_frame(input int trunc, input int err_word);
        int nwords, pad;
        logic [31:0] w;
        nwords = (fb.size() + 3) / 4;
        pad    = nwords * 4 - fb.size();
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                w[31-8*k -: 8] = (i*4 + k < fb.size()) ? fb[i*4 + k] : 8'h00;
            data_in = w;
            sop     = (i == 0);
            eop     = (i == nwords - 1);
            empty   = (i == nwords - 1) ? 2'(pad + trunc) : 2'd0;
            error   = (i == err_word) ? 6'h3F : 6'h00;
            valid   = 1'b1;
            ready   = 1'b1;
            if (err_word < 0 || i < err_word) q.push_back('{data: w, due: cyc + 4});
        end
        @(negedge clk);
        valid = 1'b0; sop = 1'b0; eop = 1'b0; error = 6'h00; empty = 2'd0;
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update_done = 1'b1;
        @(negedge clk);
        update_done = 1'b0;
    endtask

    task automatic check_hits(input string tag, input logic [63:0] m, input logic [63:0] i,
                              input logic [63:0] p, input logic [63:0] u);
        repeat (2) @(negedge clk);
        check({tag, ".mac"},  mac_hits,  m);
        check({tag, ".ip"},   ip_hits,   i);
        check({tag, ".port"}, port_hits, p);
        check({tag, ".url"},  url_hits,  u);
    endtask

    initial begin
        n_rst = 1'b1; data_in = '0; sop = 0; eop = 0; empty = 0; error = 0;
        valid = 0; ready = 0; update_done = 0;
        flagged_mac    = 48'h6412_25eb_1080;
        flagged_ip     = 32'h80d2_07c8;
        flagged_port   = 16'd80;
        flagged_string = {32'd0, "www.wired.com"};
        strlen         = 5'd13;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        check("rst.data_out", 64'(data_out), 64'd0);
        check("rst.addr_out", 64'(addr_out), 64'd0);
        check("rst.write_enable", 64'(write_enable), 64'd0);
        check("rst.mac", mac_hits, 64'd0);
        check("rst.ip", ip_hits, 64'd0);
        check("rst.port", port_hits, 64'd0);
        check("rst.url", url_hits, 64'd0);
        mon_en = 1'b1;

        build_frame(48'h6412_25eb_1080, 32'h80d2_07c8, 16'd80, 0, "www.purdue.edu", 1'b1);
        send_frame(0, -1);
        check_hits("f1_pre", 0, 0, 0, 0);
        pulse_update();
        check_hits("f1", 1, 1, 1, 0);

        build_frame(48'h6412_25eb_1080, 32'hc0a8_0001, 16'd80, 0, "www.wired.com", 1'b1);
        send_frame(0, -1);
        pulse_update();
        check_hits("f2", 2, 1, 2, 1);

        build_frame(48'h6412_25eb_1080, 32'h80d2_07c8, 16'd80, 0, "www.wired.com", 1'b1);
        send_frame(0, 5);
        pulse_update();
        check_hits("f3_err", 2, 1, 2, 1);

        for (int p = 0; p < 4; p++) begin
            build_frame(48'h0200_0000_0099, 32'hc0a8_0002, 16'h1f90, p, "www.wired.com", 1'b1);
            send_frame(0, -1);
            pulse_update();
            check_hits($sformatf("align%0d", p), 2, 1, 2, 64'(2 + p));
        end

        build_frame(48'h0200_0000_0099, 32'hc0a8_0002, 16'h1f90, 3, "www.wired.com", 1'b0);
        send_frame(2, -1);
        pulse_update();
        check_hits("trunc", 2, 1, 2, 5);

        build_frame(48'h0200_0000_0099, 32'hc0a8_0002, 16'h1f90, 1, "www.wired.com", 1'b0);
        send_frame(0, -1);
        pulse_update();
        check_hits("empty2_fit", 2, 1, 2, 6);

        repeat (8) @(negedge clk);
        check("sb_drain", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
